// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Shared encoding definitions for the MIPS subset: the 4-bit mnemonic codes,
// the opcode and funct field values, the encoder FSM state type and two field
// packing helpers. The CPU control decoder imports the same package, so the
// encoder writer and the decoder reader cannot disagree on a bit pattern.
// -----------------------------------------------------------------------------
package instr_pkg;

    // Mnemonic codes on the request interface; 13..15 are illegal.
    typedef enum logic [3:0] {
        MN_ADD   = 4'd0,
        MN_SUB   = 4'd1,
        MN_AND   = 4'd2,
        MN_OR    = 4'd3,
        MN_SLT   = 4'd4,
        MN_SRA   = 4'd5,
        MN_SRAV  = 4'd6,
        MN_ADDI  = 4'd7,
        MN_SLTIU = 4'd8,
        MN_LUI   = 4'd9,
        MN_ORI   = 4'd10,
        MN_BEQ   = 4'd11,
        MN_BNE   = 4'd12
    } mnem_e;

    // Encoder sequencing states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } enc_state_e;

    // Primary opcodes (instruction bits 31:26).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // R-type function codes (instruction bits 5:0).
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    // {000000, rs, rt, rd, shamt, funct}
    function automatic logic [31:0] r_type(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    // {op, rs, rt, imm}; the immediate is passed through without extension.
    function automatic logic [31:0] i_type(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational packer: mnemonic plus register/immediate fields in,
// 32-bit MIPS word and an illegal-mnemonic flag out. Fields the chosen format
// does not use are forced to zero.
//
// Ports:
//   mnem     in  4   mnemonic code (instr_pkg::mnem_e values, 13..15 illegal)
//   rs/rt/rd in  5   register fields
//   shamt    in  5   shift amount, only used by SRA
//   imm      in  16  immediate / branch offset, passed raw
//   word     out 32  encoded instruction (0 when illegal)
//   illegal  out 1   mnemonic is not in the supported set
// -----------------------------------------------------------------------------
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        // NOTE: both outputs get a default before the case so every path
        // assigns them and no latch is inferred.
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:   word = r_type(rs, rt, rd, 5'd0, FN_ADD);
            MN_SUB:   word = r_type(rs, rt, rd, 5'd0, FN_SUB);
            MN_AND:   word = r_type(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:    word = r_type(rs, rt, rd, 5'd0, FN_OR);
            MN_SLT:   word = r_type(rs, rt, rd, 5'd0, FN_SLT);
            // Immediate shift: the rs slot is unused, shamt carries the count.
            MN_SRA:   word = r_type(5'd0, rt, rd, shamt, FN_SRA);
            // Variable shift: the count comes from rs, so shamt is zero.
            MN_SRAV:  word = r_type(rs, rt, rd, 5'd0, FN_SRAV);
            MN_ADDI:  word = i_type(OP_ADDI, rs, rt, imm);
            MN_SLTIU: word = i_type(OP_SLTIU, rs, rt, imm);
            // LUI has no source register.
            MN_LUI:   word = i_type(OP_LUI, 5'd0, rt, imm);
            MN_ORI:   word = i_type(OP_ORI, rs, rt, imm);
            MN_BEQ:   word = i_type(OP_BEQ, rs, rt, imm);
            MN_BNE:   word = i_type(OP_BNE, rs, rt, imm);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Loads a program into instruction memory: accepts symbolic instruction
// requests, encodes them with instr_pack, and presents each word on a single
// registered, back-pressured write port at consecutive word addresses.
//
// Ports:
//   clk_i        in  1       clock, rising edge
//   rst_i        in  1       synchronous active-high reset
//   start_i      in  1       begin a new program (clears count/err/pending)
//   req_valid_i  in  1       request present
//   req_ready_o  out 1       request taken when valid & ready
//   mnem_i       in  4       mnemonic code
//   rs_i/rt_i/rd_i in 5      register fields
//   shamt_i      in  5       shift amount (SRA)
//   imm_i        in  16      immediate / branch offset
//   wr_valid_o   out 1       write word pending
//   mem_ready_i  in  1       memory takes the pending word this cycle
//   wr_addr_o    out ADDR_W  byte address of the pending word
//   wr_data_o    out 32      encoded word
//   count_o      out ADDR_W  words handed to memory since start_i
//   done_o       out 1       DEPTH words written and nothing pending
//   err_o        out 1       sticky illegal-mnemonic flag
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        mnem_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       imm_i,
    output logic              wr_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [ADDR_W-1:0] count_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] DEPTH_W  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

    enc_state_e        state;
    logic [ADDR_W-1:0] addr_q;    // address the next legal word will use
    logic [ADDR_W-1:0] acc_cnt;   // legal words accepted in this program

    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic        hshake;
    logic        load;

    instr_pack u_pack (
        .mnem    (mnem_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .shamt   (shamt_i),
        .imm     (imm_i),
        .word    (word),
        .illegal (illegal)
    );

    // The single output register can be refilled in the same cycle it drains,
    // so a stalled memory is the only thing that blocks a request in RUN.
    // start_i blocks requests so the restart never races a new word.
    assign req_ready_o = (state == S_RUN) && !start_i
                         && (!wr_valid_o || mem_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign hshake      = wr_valid_o && mem_ready_i;
    assign load        = accept && !illegal;

    // Decoded from registers only, so it is as clean as a registered output.
    assign done_o      = (state == S_FULL) && !wr_valid_o;

    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; blocking assignments would make the
    // result depend on statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            addr_q     <= BASE_ADDR;
            acc_cnt    <= '0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            count_o    <= '0;
            err_o      <= 1'b0;
        end else if (start_i) begin
            // Restart from any state; a pending word is discarded.
            state      <= S_RUN;
            addr_q     <= BASE_ADDR;
            acc_cnt    <= '0;
            wr_valid_o <= 1'b0;
            count_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            if (hshake) begin
                count_o <= count_o + ONE;
            end

            if (load) begin
                wr_valid_o <= 1'b1;
                wr_data_o  <= word;
                wr_addr_o  <= addr_q;
                addr_q     <= addr_q + WORD_INC;   // wraps modulo 2^ADDR_W
                acc_cnt    <= acc_cnt + ONE;
                if (acc_cnt + ONE == DEPTH_W) begin
                    state <= S_FULL;
                end
            end else if (hshake) begin
                wr_valid_o <= 1'b0;
            end

            // An illegal request is consumed but produces nothing.
            if (accept && illegal) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder (DEPTH = 4): a table of encodings,
// hand-written sequences for back-to-back writes, stalls, illegal mnemonics,
// program-full, restart and reset, then randomized traffic checked against a
// transaction-level model (expected-write queue plus program counters).
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    import instr_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int N_RND  = 3000;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [3:0]        mnem_i = '0;
    logic [4:0]        rs_i = '0;
    logic [4:0]        rt_i = '0;
    logic [4:0]        rd_i = '0;
    logic [4:0]        shamt_i = '0;
    logic [15:0]       imm_i = '0;
    logic              wr_valid_o;
    logic              mem_ready_i = 1'b1;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic [ADDR_W-1:0] count_o;
    logic              done_o;
    logic              err_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .mnem_i      (mnem_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .rd_i        (rd_i),
        .shamt_i     (shamt_i),
        .imm_i       (imm_i),
        .wr_valid_o  (wr_valid_o),
        .mem_ready_i (mem_ready_i),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .count_o     (count_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    // ---------------- reference encoder (from the field rules) ---------------
    int op_of [13] = '{0, 0, 0, 0, 0, 0, 0, 8, 11, 15, 13, 4, 5};
    int fn_of [13] = '{32, 34, 36, 37, 42, 3, 7, 0, 0, 0, 0, 0, 0};

    function automatic logic [31:0] ref_encode(input int mn, input int rs,
                                               input int rt, input int rd,
                                               input int sh, input int imm);
        longint w;
        if (mn > 12) return 32'd0;
        if (mn <= 6) begin
            // R-type: SRA drops rs and keeps shamt, all others drop shamt
            w = longint'(mn == 5 ? 0 : rs) * (1 << 21) + longint'(rt) * (1 << 16)
              + longint'(rd) * (1 << 11) + longint'(mn == 5 ? sh : 0) * 64
              + longint'(fn_of[mn]);
        end else begin
            // I-type: LUI drops rs
            w = longint'(op_of[mn]) * (1 << 26) + longint'(mn == 9 ? 0 : rs) * (1 << 21)
              + longint'(rt) * (1 << 16) + longint'(imm);
        end
        return w[31:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [3:0] mn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [15:0] imm);
        mnem_i = mn; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = sh; imm_i = imm;
        req_valid_i = 1'b1;
    endtask

    task automatic do_start();
        req_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // ---------------- encoding table ----------------
    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [31:0] word;
        bit          illegal;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    // ---------------- random-phase model state ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  m_q[$];
    wr_t  got[$];
    bit   m_active;
    int   m_legal_n;
    int   m_count;
    bit   m_err;
    bit   p_start, p_acc, p_hs, p_legal, exp_ready;
    logic [31:0] p_word;

    initial begin
        tbl[0]  = '{MN_ADDI,  5'd0,  5'd1,  5'd31, 5'd31, 16'h0005, 32'h20010005, 1'b0};
        tbl[1]  = '{MN_ADD,   5'd1,  5'd2,  5'd3,  5'd0,  16'hFFFF, 32'h00221820, 1'b0};
        tbl[2]  = '{MN_SRA,   5'd7,  5'd2,  5'd4,  5'd3,  16'h0000, 32'h000220C3, 1'b0};
        tbl[3]  = '{MN_LUI,   5'd7,  5'd5,  5'd0,  5'd0,  16'h1234, 32'h3C051234, 1'b0};
        tbl[4]  = '{MN_BEQ,   5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 32'h1022FFFF, 1'b0};
        tbl[5]  = '{MN_SUB,   5'd3,  5'd4,  5'd5,  5'd9,  16'h0000, 32'h00642822, 1'b0};
        tbl[6]  = '{MN_AND,   5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 32'h03FFF824, 1'b0};
        tbl[7]  = '{MN_OR,    5'd0,  5'd0,  5'd1,  5'd0,  16'h0000, 32'h00000825, 1'b0};
        tbl[8]  = '{MN_SLT,   5'd2,  5'd3,  5'd1,  5'd0,  16'h0000, 32'h0043082A, 1'b0};
        tbl[9]  = '{MN_SRAV,  5'd5,  5'd6,  5'd7,  5'd4,  16'h0000, 32'h00A63807, 1'b0};
        tbl[10] = '{MN_SLTIU, 5'd4,  5'd5,  5'd0,  5'd0,  16'h8000, 32'h2C858000, 1'b0};
        tbl[11] = '{MN_ORI,   5'd1,  5'd1,  5'd0,  5'd0,  16'hABCD, 32'h3421ABCD, 1'b0};
        tbl[12] = '{MN_BNE,   5'd8,  5'd9,  5'd0,  5'd0,  16'h0010, 32'h15090010, 1'b0};
        tbl[13] = '{4'd13,    5'd1,  5'd1,  5'd1,  5'd1,  16'h1111, 32'h00000000, 1'b1};
        tbl[14] = '{4'd15,    5'd2,  5'd2,  5'd2,  5'd2,  16'h2222, 32'h00000000, 1'b1};

        // ---------------- reset state ----------------
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_wr_valid", wr_valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", wr_addr_o, 0);
        req_valid_i = 1'b1;
        #1;
        check("idle_ready", req_ready_o, 0);
        req_valid_i = 1'b0;

        // ---------------- table: one word per program ----------------
        mem_ready_i = 1'b1;
        for (int i = 0; i < NV; i++) begin
            do_start();
            set_req(tbl[i].mnem, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].imm);
            #1;
            check("tbl_ready", req_ready_o, 1);
            tick();
            req_valid_i = 1'b0;
            if (tbl[i].illegal) begin
                check("tbl_ill_valid", wr_valid_o, 0);
                check("tbl_ill_err", err_o, 1);
            end else begin
                check("tbl_valid", wr_valid_o, 1);
                check("tbl_data", wr_data_o, tbl[i].word);
                check("tbl_addr", wr_addr_o, 0);
                check("tbl_err", err_o, 0);
            end
            tick();
            check("tbl_count", count_o, tbl[i].illegal ? 0 : 1);
            check("tbl_drain", wr_valid_o, 0);
        end

        // ---------------- back-to-back, then a 3-cycle stall ----------------
        do_start();
        set_req(MN_LUI, 5'd0, 5'd5, 5'd0, 5'd0, 16'h1234);
        tick();
        set_req(MN_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
        #1;
        check("b2b_ready", req_ready_o, 1);
        check("b2b_lui_data", wr_data_o, 32'h3C051234);
        check("b2b_lui_addr", wr_addr_o, 32'h0);
        tick();
        check("b2b_beq_data", wr_data_o, 32'h1022FFFF);
        check("b2b_beq_addr", wr_addr_o, 32'h4);
        check("b2b_count", count_o, 1);
        set_req(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        mem_ready_i = 1'b0;
        #1;
        check("stall_ready", req_ready_o, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_valid", wr_valid_o, 1);
            check("stall_data", wr_data_o, 32'h1022FFFF);
            check("stall_addr", wr_addr_o, 32'h4);
            check("stall_count", count_o, 1);
            #1;
            check("stall_ready", req_ready_o, 0);
        end
        mem_ready_i = 1'b1;
        #1;
        check("release_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        check("release_data", wr_data_o, 32'h00221820);
        check("release_addr", wr_addr_o, 32'h8);
        check("release_count", count_o, 2);
        tick();
        check("release_drain", wr_valid_o, 0);
        check("release_count2", count_o, 3);
        check("release_done", done_o, 0);

        // ---------------- illegal mnemonic ----------------
        do_start();
        set_req(MN_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005);
        tick();
        set_req(4'd14, 5'd3, 5'd3, 5'd3, 5'd3, 16'h3333);
        tick();
        check("ill_err", err_o, 1);
        check("ill_valid", wr_valid_o, 0);
        check("ill_count", count_o, 1);
        set_req(MN_ORI, 5'd1, 5'd1, 5'd0, 5'd0, 16'hABCD);
        tick();
        req_valid_i = 1'b0;
        check("ill_next_addr", wr_addr_o, 32'h4);
        check("ill_next_data", wr_data_o, 32'h3421ABCD);
        check("ill_sticky", err_o, 1);
        tick();
        check("ill_count2", count_o, 2);
        check("ill_sticky2", err_o, 1);
        do_start();
        check("start_clr_err", err_o, 0);
        check("start_clr_count", count_o, 0);

        // ---------------- program full with six requests ----------------
        got.delete();
        for (int c = 0; c < 6; c++) begin
            set_req(MN_ADDI, 5'd0, 5'd2, 5'd0, 5'd0, 16'(c));
            tick();
            if (wr_valid_o) got.push_back('{wr_addr_o, wr_data_o});
        end
        #1;
        check("full_ready", req_ready_o, 0);
        check("full_writes", got.size(), 4);
        for (int k = 0; k < got.size(); k++) begin
            check("full_addr", got[k].addr, 32'(4 * k));
            check("full_data", got[k].data, 32'h20020000 | 32'(k));
        end
        check("full_done", done_o, 1);
        check("full_count", count_o, 4);

        // start wins over a simultaneous request
        set_req(MN_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0077);
        start_i = 1'b1;
        #1;
        check("start_req_ready", req_ready_o, 0);
        tick();
        start_i = 1'b0;
        req_valid_i = 1'b0;
        check("start_req_valid", wr_valid_o, 0);
        check("start_req_count", count_o, 0);
        check("start_req_done", done_o, 0);
        set_req(MN_ADDI, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0042);
        tick();
        req_valid_i = 1'b0;
        check("restart_addr", wr_addr_o, 32'h0);
        check("restart_data", wr_data_o, 32'h20030042);

        // ---------------- reset with a word pending ----------------
        mem_ready_i = 1'b0;
        do_start();
        set_req(MN_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001);
        tick();
        req_valid_i = 1'b0;
        check("pre_rst_valid", wr_valid_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_valid", wr_valid_o, 0);
        check("mid_rst_count", count_o, 0);
        check("mid_rst_addr", wr_addr_o, 0);
        check("mid_rst_data", wr_data_o, 0);
        check("mid_rst_done", done_o, 0);
        set_req(MN_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001);
        #1;
        check("mid_rst_ready", req_ready_o, 0);
        req_valid_i = 1'b0;

        // ---------------- randomized traffic vs model ----------------
        m_q.delete();
        m_active = 0; m_legal_n = 0; m_count = 0; m_err = 0;
        p_start = 0; p_acc = 0; p_hs = 0; p_legal = 0; p_word = '0;
        for (int n = 0; n < N_RND; n++) begin
            tick();
            // apply the events of the edge just taken
            if (p_start) begin
                m_active = 1; m_count = 0; m_err = 0; m_legal_n = 0;
                m_q.delete();
            end else begin
                if (p_hs) begin
                    void'(m_q.pop_front());
                    m_count++;
                end
                if (p_acc) begin
                    if (p_legal) begin
                        m_q.push_back('{32'(4 * m_legal_n), p_word});
                        m_legal_n++;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            check("rnd_valid", wr_valid_o, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("rnd_addr", wr_addr_o, m_q[0].addr);
                check("rnd_data", wr_data_o, m_q[0].data);
            end
            check("rnd_count", count_o, 32'(m_count));
            check("rnd_err", err_o, m_err);
            check("rnd_done", done_o, m_active && m_legal_n == DEPTH && m_q.size() == 0);

            // new stimulus
            start_i     = (n == 0) || ($urandom_range(0, 29) == 0);
            req_valid_i = ($urandom_range(0, 9) < 7);
            mem_ready_i = ($urandom_range(0, 9) < 6);
            mnem_i      = 4'($urandom_range(0, 15));
            rs_i        = 5'($urandom);
            rt_i        = 5'($urandom);
            rd_i        = 5'($urandom);
            shamt_i     = 5'($urandom);
            imm_i       = 16'($urandom);
            #1;
            exp_ready = m_active && (m_legal_n < DEPTH) && !start_i
                        && (m_q.size() == 0 || mem_ready_i);
            check("rnd_ready", req_ready_o, exp_ready);
            p_start = start_i;
            p_acc   = req_valid_i && exp_ready;
            p_hs    = (m_q.size() != 0) && mem_ready_i;
            p_legal = (int'(mnem_i) <= 12);
            p_word  = ref_encode(int'(mnem_i), int'(rs_i), int'(rt_i), int'(rd_i),
                                 int'(shamt_i), int'(imm_i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
